// File: rtl/cdb_host_regs.sv
// CD-block host register file on the SCU A-bus CS2 window: CR1..CR4 command and
// response registers, maskable HIRQ flags, sector-data FIFO and programmable bus wait.
module cdb_host_regs #(
  parameter logic [9:0]  BASE_PAGE   = 10'h189,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [63:0] RST_CR      = 64'h0043_4442_4C4F_434B
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic [25:0] AA,
  input  logic        CS_N,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  input  logic        RD_N,
  input  logic        WRU_N,
  input  logic        WRL_N,
  output logic        WAIT_N,
  output logic        IRQ_N,
  output logic        CMD_VALID,
  output logic [63:0] CMD_DATA,
  input  logic        RSP_VALID,
  input  logic [63:0] RSP_DATA,
  input  logic [15:0] HIRQ_SET,
  input  logic        DATA_WR,
  input  logic [15:0] DATA_DI,
  output logic        DATA_FULL
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? WCW'(WAIT_CYCLES - 1) : '0;

  localparam logic [15:0] OFF_DATA = 16'h0000;
  localparam logic [15:0] OFF_HIRQ = 16'h0008;
  localparam logic [15:0] OFF_MASK = 16'h000C;
  localparam logic [15:0] OFF_CR1  = 16'h0018;
  localparam logic [15:0] OFF_CR2  = 16'h001C;
  localparam logic [15:0] OFF_CR3  = 16'h0020;
  localparam logic [15:0] OFF_CR4  = 16'h0024;

  function automatic logic [15:0] byteMerge(input logic [15:0] oldVal,
                                            input logic [15:0] newVal,
                                            input logic [1:0]  be);
    byteMerge = {be[1] ? newVal[15:8] : oldVal[15:8],
                 be[0] ? newVal[7:0]  : oldVal[7:0]};
  endfunction

  logic          sel;
  logic          sel_q;
  logic          start;
  logic          readAcc;
  logic          writeAcc;
  logic [1:0]    byteEn;
  logic [15:0]   offset;
  logic          unusedAddrBit;

  logic [15:0]   do_q;
  logic          waitN_q;
  logic [WCW-1:0] waitCnt_q;
  logic          irqN_q;
  logic          cmdValid_q;
  logic          cmdIssue;
  logic [63:0]   cmdData_q;
  logic [15:0]   cmdCr1_q, cmdCr2_q, cmdCr3_q, cmdCr4_q;
  logic [15:0]   cr4Merged;
  logic [63:0]   rsp_q;
  logic [15:0]   hirq_q, hirq_d;
  logic [15:0]   hirqMask_q, hirqMask_d;
  logic [15:0]   readData;

  logic [15:0]   fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic          fifoEmpty;
  logic          fifoFull;
  logic          push;
  logic          pop;

  assign unusedAddrBit = AA[0];

  assign sel      = !CS_N && (AA[25:16] == BASE_PAGE) && (!RD_N || !WRU_N || !WRL_N);
  assign start    = CE_R && sel && !sel_q;
  assign offset   = {AA[15:1], 1'b0};
  assign byteEn   = {!WRU_N, !WRL_N};
  assign readAcc  = start && !RD_N;
  assign writeAcc = start && (byteEn != 2'b00);

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CW'(FIFO_DEPTH));
  assign push      = CE_R && DATA_WR && !fifoFull;
  assign pop       = readAcc && (offset == OFF_DATA) && !fifoEmpty;

  assign cmdIssue  = writeAcc && (offset == OFF_CR4);
  assign cr4Merged = byteMerge(cmdCr4_q, DI, byteEn);

  // Read mux is sampled only at access start; response CRs are read before any
  // same-cycle RSP_VALID load so the host sees the pre-update value.
  always_comb begin
    readData = '0;
    case (offset)
      OFF_DATA: readData = fifoEmpty ? 16'h0000 : fifoMem[rdPtr_q];
      OFF_HIRQ: readData = hirq_q;
      OFF_MASK: readData = hirqMask_q;
      OFF_CR1:  readData = rsp_q[63:48];
      OFF_CR2:  readData = rsp_q[47:32];
      OFF_CR3:  readData = rsp_q[31:16];
      OFF_CR4:  readData = rsp_q[15:0];
      default:  readData = '0;
    endcase
  end

  // Clears are applied first so that every set source wins on a shared bit.
  always_comb begin
    hirq_d = hirq_q;
    if (writeAcc && (offset == OFF_HIRQ)) begin
      hirq_d = hirq_d & {byteEn[1] ? DI[15:8] : 8'hFF, byteEn[0] ? DI[7:0] : 8'hFF};
    end
    if (cmdIssue) begin
      hirq_d[0] = 1'b0;
    end
    hirq_d = hirq_d | HIRQ_SET;
    if (RSP_VALID) begin
      hirq_d[0] = 1'b1;
    end
  end

  always_comb begin
    hirqMask_d = hirqMask_q;
    if (writeAcc && (offset == OFF_MASK)) begin
      hirqMask_d = byteMerge(hirqMask_q, DI, byteEn);
    end
  end

  // Host-side registers, handshake and interrupt; everything is frozen while CE_R=0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q      <= 1'b0;
      do_q       <= '0;
      irqN_q     <= 1'b1;
      cmdValid_q <= 1'b0;
      cmdData_q  <= '0;
      cmdCr1_q   <= '0;
      cmdCr2_q   <= '0;
      cmdCr3_q   <= '0;
      cmdCr4_q   <= '0;
      rsp_q      <= RST_CR;
      hirq_q     <= 16'h0001;
      hirqMask_q <= '0;
    end else if (CE_R) begin
      sel_q      <= sel;
      hirq_q     <= hirq_d;
      hirqMask_q <= hirqMask_d;
      irqN_q     <= ~|(hirq_q & hirqMask_q);
      cmdValid_q <= cmdIssue;
      if (start) begin
        do_q <= readAcc ? readData : 16'h0000;
      end
      if (writeAcc && (offset == OFF_CR1)) cmdCr1_q <= byteMerge(cmdCr1_q, DI, byteEn);
      if (writeAcc && (offset == OFF_CR2)) cmdCr2_q <= byteMerge(cmdCr2_q, DI, byteEn);
      if (writeAcc && (offset == OFF_CR3)) cmdCr3_q <= byteMerge(cmdCr3_q, DI, byteEn);
      if (cmdIssue) begin
        cmdCr4_q  <= cr4Merged;
        cmdData_q <= {cmdCr1_q, cmdCr2_q, cmdCr3_q, cr4Merged};
      end
      if (RSP_VALID) begin
        rsp_q <= RSP_DATA;
      end
    end
  end

  // Bus wait: pulled low at access start and released after WAIT_CYCLES CE_R cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      waitN_q   <= 1'b1;
      waitCnt_q <= '0;
    end else if (CE_R) begin
      if (start && (WAIT_CYCLES != 0)) begin
        waitN_q   <= 1'b0;
        waitCnt_q <= WAIT_LOAD;
      end else if (!waitN_q) begin
        if (waitCnt_q == '0) begin
          waitN_q <= 1'b1;
        end else begin
          waitCnt_q <= waitCnt_q - WCW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifoMem[wrPtr_q] <= DATA_DI;
    end
  end

  assign DO        = do_q;
  assign WAIT_N    = waitN_q;
  assign IRQ_N     = irqN_q;
  assign CMD_VALID = cmdValid_q;
  assign CMD_DATA  = cmdData_q;
  assign DATA_FULL = fifoFull;

endmodule

// File: tb/tb_cdb_host_regs.sv
// Randomised scoreboard bench for cdb_host_regs: a high-level register/FIFO model
// predicts read data and commands; a monitor checks them as the DUT presents them.
module tb_cdb_host_regs;

  localparam logic [9:0] BASE_PAGE   = 10'h189;
  localparam int         FIFO_DEPTH  = 16;
  localparam int         WAIT_CYCLES = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE_R = 1'b1;
  logic [25:0] AA = '0;
  logic        CS_N = 1'b1;
  logic [15:0] DI = '0;
  logic [15:0] DO;
  logic        RD_N = 1'b1;
  logic        WRU_N = 1'b1;
  logic        WRL_N = 1'b1;
  logic        WAIT_N;
  logic        IRQ_N;
  logic        CMD_VALID;
  logic [63:0] CMD_DATA;
  logic        RSP_VALID = 1'b0;
  logic [63:0] RSP_DATA = '0;
  logic [15:0] HIRQ_SET = '0;
  logic        DATA_WR = 1'b0;
  logic [15:0] DATA_DI = '0;
  logic        DATA_FULL;

  cdb_host_regs #(
    .BASE_PAGE(BASE_PAGE), .FIFO_DEPTH(FIFO_DEPTH), .WAIT_CYCLES(WAIT_CYCLES),
    .RST_CR(64'h0043_4442_4C4F_434B)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .AA(AA), .CS_N(CS_N), .DI(DI), .DO(DO),
    .RD_N(RD_N), .WRU_N(WRU_N), .WRL_N(WRL_N), .WAIT_N(WAIT_N), .IRQ_N(IRQ_N),
    .CMD_VALID(CMD_VALID), .CMD_DATA(CMD_DATA), .RSP_VALID(RSP_VALID),
    .RSP_DATA(RSP_DATA), .HIRQ_SET(HIRQ_SET), .DATA_WR(DATA_WR), .DATA_DI(DATA_DI),
    .DATA_FULL(DATA_FULL)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        isRead;
    logic [15:0] exp;
    logic [15:0] off;
  } accEntry_t;

  accEntry_t   accQ[$];
  logic [63:0] cmdQ[$];

  // Reference model state: plain register values and a word queue for the FIFO.
  logic [15:0] mHirq;
  logic [15:0] mMask;
  logic [15:0] mRsp[4];
  logic [15:0] mCmd[4];
  logic [15:0] mFifo[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mHirq = 16'h0001;
    mMask = 16'h0000;
    mRsp[0] = 16'h0043; mRsp[1] = 16'h4442; mRsp[2] = 16'h4C4F; mRsp[3] = 16'h434B;
    for (int i = 0; i < 4; i++) mCmd[i] = 16'h0000;
    mFifo.delete();
  endtask

  function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    logic [15:0] r;
    r = o;
    if (be[1]) r[15:8] = n[15:8];
    if (be[0]) r[7:0]  = n[7:0];
    return r;
  endfunction

  // One host access as the register map describes it; reads see the state before writes.
  task automatic modelAccess(input logic [15:0] off, input logic rd, input logic [1:0] be,
                             input logic [15:0] d, output logic [15:0] rdExp);
    rdExp = 16'h0000;
    if (rd) begin
      case (off)
        16'h0000: if (mFifo.size() > 0) rdExp = mFifo.pop_front();
        16'h0008: rdExp = mHirq;
        16'h000C: rdExp = mMask;
        16'h0018: rdExp = mRsp[0];
        16'h001C: rdExp = mRsp[1];
        16'h0020: rdExp = mRsp[2];
        16'h0024: rdExp = mRsp[3];
        default:  rdExp = 16'h0000;
      endcase
    end
    if (be != 2'b00) begin
      case (off)
        16'h0008: begin
          if (be[1]) mHirq[15:8] = mHirq[15:8] & d[15:8];
          if (be[0]) mHirq[7:0]  = mHirq[7:0]  & d[7:0];
        end
        16'h000C: mMask = merge16(mMask, d, be);
        16'h0018: mCmd[0] = merge16(mCmd[0], d, be);
        16'h001C: mCmd[1] = merge16(mCmd[1], d, be);
        16'h0020: mCmd[2] = merge16(mCmd[2], d, be);
        16'h0024: begin
          mCmd[3] = merge16(mCmd[3], d, be);
          cmdQ.push_back({mCmd[0], mCmd[1], mCmd[2], mCmd[3]});
          mHirq[0] = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic checkStatus();
    checkOutput("IRQ_N", 64'(IRQ_N), 64'(~|(mHirq & mMask)));
    checkOutput("DATA_FULL", 64'(DATA_FULL), 64'(mFifo.size() == FIFO_DEPTH));
  endtask

  // Drives one bus cycle (possibly a non-access) with optional same-cycle set/response events.
  task automatic applyStimulus(input logic [25:0] addr, input logic csN, input logic rd,
                               input logic [1:0] be, input logic [15:0] data,
                               input logic rspPulse, input logic [63:0] rspData,
                               input logic [15:0] setBits);
    logic [15:0] rdExp;
    logic [15:0] off;
    off = {addr[15:1], 1'b0};
    if (!csN && addr[25:16] == BASE_PAGE && (rd || be != 2'b00)) begin
      modelAccess(off, rd, be, data, rdExp);
      accQ.push_back('{isRead: rd, exp: rdExp, off: off});
    end
    mHirq = mHirq | setBits;
    if (rspPulse) begin
      mRsp[0] = rspData[63:48]; mRsp[1] = rspData[47:32];
      mRsp[2] = rspData[31:16]; mRsp[3] = rspData[15:0];
      mHirq[0] = 1'b1;
    end
    @(negedge CLK);
    AA = addr; CS_N = csN; RD_N = !rd; WRU_N = !be[1]; WRL_N = !be[0]; DI = data;
    RSP_VALID = rspPulse; RSP_DATA = rspData; HIRQ_SET = setBits;
    @(negedge CLK);
    RSP_VALID = 1'b0; HIRQ_SET = 16'h0000;
    repeat (3) @(negedge CLK);
    CS_N = 1'b1; RD_N = 1'b1; WRU_N = 1'b1; WRL_N = 1'b1;
    repeat (2) @(negedge CLK);
    checkStatus();
  endtask

  task automatic hostRead(input logic [15:0] off);
    applyStimulus({BASE_PAGE, off[15:1], 1'b0}, 1'b0, 1'b1, 2'b00, 16'h0, 1'b0, 64'h0, 16'h0);
  endtask

  task automatic hostWrite(input logic [15:0] off, input logic [15:0] d);
    applyStimulus({BASE_PAGE, off[15:1], 1'b0}, 1'b0, 1'b0, 2'b11, d, 1'b0, 64'h0, 16'h0);
  endtask

  task automatic pushWord(input logic [15:0] d);
    if (mFifo.size() < FIFO_DEPTH) mFifo.push_back(d);
    @(negedge CLK);
    DATA_WR = 1'b1; DATA_DI = d;
    @(negedge CLK);
    DATA_WR = 1'b0;
    @(negedge CLK);
    checkOutput("DATA_FULL", 64'(DATA_FULL), 64'(mFifo.size() == FIFO_DEPTH));
  endtask

  // Monitor: WAIT_N falling marks an access start, when DO carries the read data.
  logic prevWaitN = 1'b1;
  int   lowCnt = 0;
  always @(negedge CLK) begin
    accEntry_t e;
    logic [63:0] c;
    if (!RST_N) begin
      prevWaitN = 1'b1;
      lowCnt = 0;
    end else begin
      if (prevWaitN && !WAIT_N) begin
        if (accQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL accessStart: WAIT_N fell with no access pending, DO=%h", DO);
        end else begin
          e = accQ.pop_front();
          if (e.isRead) checkOutput($sformatf("read@%h", e.off), 64'(DO), 64'(e.exp));
        end
      end
      if (!WAIT_N) lowCnt++;
      else if (!prevWaitN) begin
        checkOutput("waitLength", 64'(lowCnt), 64'(WAIT_CYCLES));
        lowCnt = 0;
      end
      prevWaitN = WAIT_N;
      if (CMD_VALID) begin
        if (cmdQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL cmdValid: unexpected pulse, CMD_DATA=%h", CMD_DATA);
        end else begin
          c = cmdQ.pop_front();
          checkOutput("CMD_DATA", CMD_DATA, c);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] offList[10];
    logic [15:0] off;
    logic [9:0]  page;
    int          r;
    offList = '{16'h0000, 16'h0008, 16'h000C, 16'h0018, 16'h001C,
                16'h0020, 16'h0024, 16'h0004, 16'h0010, 16'h002E};

    modelReset();
    repeat (3) @(negedge CLK);
    checkOutput("reset DO", 64'(DO), 64'h0);
    checkOutput("reset WAIT_N", 64'(WAIT_N), 64'h1);
    checkOutput("reset IRQ_N", 64'(IRQ_N), 64'h1);
    checkOutput("reset CMD_VALID", 64'(CMD_VALID), 64'h0);
    checkOutput("reset CMD_DATA", CMD_DATA, 64'h0);
    checkOutput("reset DATA_FULL", 64'(DATA_FULL), 64'h0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    hostRead(16'h0018); hostRead(16'h001C); hostRead(16'h0020); hostRead(16'h0024);
    hostRead(16'h0008);

    hostWrite(16'h0018, 16'h0100); hostWrite(16'h001C, 16'h0200);
    hostWrite(16'h0020, 16'h0300); hostWrite(16'h0024, 16'h0400);
    hostRead(16'h0008);

    hostWrite(16'h000C, 16'h0001);
    applyStimulus('0, 1'b1, 1'b0, 2'b00, 16'h0, 1'b1, 64'h1111_2222_3333_4444, 16'h0);
    hostRead(16'h0018); hostRead(16'h001C); hostRead(16'h0020); hostRead(16'h0024);
    hostRead(16'h0008);
    hostWrite(16'h0008, 16'hFFFE);

    for (int i = 0; i <= FIFO_DEPTH; i++) pushWord(16'(i));
    for (int i = 0; i <= FIFO_DEPTH; i++) hostRead(16'h0000);

    applyStimulus({BASE_PAGE, 15'h0004, 1'b0}, 1'b0, 1'b0, 2'b11, 16'hFFFB, 1'b0, 64'h0, 16'h0004);
    hostRead(16'h0008);

    applyStimulus({BASE_PAGE, 15'h000C, 1'b0}, 1'b0, 1'b1, 2'b00, 16'h0, 1'b1,
                  64'hA5A5_5A5A_0F0F_F0F0, 16'h0);
    hostRead(16'h0018);

    pushWord(16'hABCD);
    @(negedge CLK);
    CE_R = 1'b0; AA = {BASE_PAGE, 16'h0000}; CS_N = 1'b0; RD_N = 1'b0;
    DATA_WR = 1'b1; DATA_DI = 16'h1234; HIRQ_SET = 16'h0100; RSP_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    CS_N = 1'b1; RD_N = 1'b1; DATA_WR = 1'b0; HIRQ_SET = 16'h0; RSP_VALID = 1'b0;
    @(negedge CLK);
    CE_R = 1'b1;
    repeat (2) @(negedge CLK);
    hostRead(16'h0000); hostRead(16'h0000); hostRead(16'h0008); hostRead(16'h0018);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      off = offList[$urandom_range(0, 9)];
      page = ($urandom_range(0, 7) == 0) ? (BASE_PAGE ^ 10'h001) : BASE_PAGE;
      if (r <= 1) begin
        pushWord(16'($urandom));
      end else if (r == 2) begin
        applyStimulus('0, 1'b1, 1'b0, 2'b00, 16'h0, 1'b1, {$urandom, $urandom}, 16'h0);
      end else if (r == 3) begin
        applyStimulus('0, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0, 64'h0, 16'($urandom & $urandom));
      end else begin
        applyStimulus({page, off[15:1], 1'($urandom_range(0, 1))},
                      ($urandom_range(0, 15) == 0), (r <= 6),
                      (r <= 6) ? 2'b00 : 2'($urandom_range(1, 3)),
                      16'($urandom), 1'b0, 64'h0, 16'h0);
      end
    end

    hostWrite(16'h0018, 16'hBEEF);
    @(negedge CLK);
    AA = {BASE_PAGE, 16'h0024}; CS_N = 1'b0; WRU_N = 1'b0; WRL_N = 1'b0; DI = 16'h7777;
    @(posedge CLK);
    #1 RST_N = 1'b0;
    @(negedge CLK);
    checkOutput("midReset CMD_VALID", 64'(CMD_VALID), 64'h0);
    checkOutput("midReset CMD_DATA", CMD_DATA, 64'h0);
    checkOutput("midReset WAIT_N", 64'(WAIT_N), 64'h1);
    checkOutput("midReset DO", 64'(DO), 64'h0);
    CS_N = 1'b1; WRU_N = 1'b1; WRL_N = 1'b1;
    modelReset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    checkStatus();
    hostRead(16'h0008); hostRead(16'h0024); hostRead(16'h0000);

    repeat (4) @(negedge CLK);
    checkOutput("access queue drained", 64'(accQ.size()), 64'h0);
    checkOutput("command queue drained", 64'(cmdQ.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
